i2c_controller: RTL and testbench
=================================

// Module: i2c_controller
// PURPOSE
//   Single-master I2C controller: the initiator for the FPGA-side I2C target.
//   Runs one single-byte write or read per command: START, addr+R/W, ACK, data, ACK/NACK, STOP.
//   Drives open-drain SCL/SDA through oe pins. Used for loopback tests and as an on-chip bus master.
// PARAMETERS
//   CLK_DIV  4  clk cycles per quarter bit; bit time = 4*CLK_DIV clk; legal range 1..65535
// PORTS
//   clk         in   1  system clock; all logic on rising edge
//   rst         in   1  synchronous reset, active-high
//   cmd_valid   in   1  command request
//   cmd_ready   out  1  high only in IDLE; transfer when cmd_valid & cmd_ready
//   cmd_addr    in   7  7-bit target address
//   cmd_rw      in   1  0 = write, 1 = read
//   cmd_wdata   in   8  write byte (ignored for reads)
//   rsp_valid   out  1  one-cycle pulse at transaction end; no backpressure
//   rsp_rdata   out  8  read byte; 0x00 after a write or an address NACK
//   rsp_nack    out  1  1 = target NACKed the address or the write data
//   i2c_scl_i   in   1  SCL pin level (synchronised externally)
//   i2c_scl_o   out  1  constant 0
//   i2c_scl_oe  out  1  1 = pull SCL low
//   i2c_sda_i   in   1  SDA pin level
//   i2c_sda_o   out  1  constant 0
//   i2c_sda_oe  out  1  1 = pull SDA low
// BEHAVIOUR
//   Reset: all oe = 0 (bus released), cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_nack = 0.
//     cmd_ready = 1 on the first cycle after rst deasserts.
//   On handshake, latch addr/rw/wdata and drop cmd_ready. Leave IDLE next cycle; that cycle starts Q0.
//   Quarter counter counts CLK_DIV-1 down to 0. A bit has quarters Q0..Q3:
//     Q0: SCL low; SDA updated at Q0 entry.  Q1: SCL low.
//     Q2: SCL released; count held while i2c_scl_i = 0 (clock stretching, no timeout).
//     Q3: SCL high. SDA sampled on the first cycle of Q3.
//   States: IDLE -> START -> ADDR(8) -> AACK -> DATA(8) -> DACK -> STOP -> DONE -> IDLE.
//     START: Q0-Q1 SCL and SDA released; Q2-Q3 SDA low; SCL pulled low at exit.
//     ADDR: shift {addr, rw} out MSB first. Bit = 0 -> sda_oe = 1; bit = 1 -> sda_oe = 0.
//     AACK: SDA released. Sampled 1 -> rsp_nack = 1, skip to STOP.
//     DATA write: shift wdata out MSB first.
//     DATA read: SDA released; sampled bits shift into rdata MSB first.
//     DACK write: SDA released; sampled 1 -> rsp_nack = 1.
//     DACK read: controller releases SDA (NACK = last byte).
//     STOP: Q0-Q1 SDA low with SCL low->released; Q2-Q3 SDA released while SCL high.
//     DONE: rsp_valid = 1 for one cycle; rsp_rdata/rsp_nack valid that cycle and held until the next rsp.
//   Latency without stretching, handshake edge to rsp_valid:
//     full transaction: 20*4*CLK_DIV + 1 clk.  address NACK: 11*4*CLK_DIV + 1 clk.
//   Stretching extends the latency by the number of cycles SCL is held low in Q2.
//   cmd_valid outside IDLE is ignored; no queueing. DONE->IDLE allows a new handshake in the cycle after rsp_valid.
//   SDA changes only while SCL is low, except START/STOP edges.
//   rst mid-transaction: next cycle both oe = 0 and state = IDLE; no STOP is issued and no rsp is produced.
//   No arbitration or multi-master support. Bit counter is 3 bits and wraps after 8.
// TESTING
//   1 CLK_DIV=4, write addr 0x42 data 0x5A, target ACKs -> SDA bits 10000100,0,01011010,0;
//     rsp_nack=0; rsp_valid at 321 clk.
//   2 Read addr 0x42, target drives 0xA5 -> rsp_rdata=0xA5, controller NACK bit = SDA high, rsp_nack=0.
//   3 No target (SDA stays high) -> STOP right after AACK; rsp_nack=1; rsp_valid at 177 clk.
//   4 Target holds SCL low 50 clk in ADDR bit 3 Q2 -> rsp_valid at 371 clk; data unchanged.
//   5 rst pulsed in DATA bit 4 -> next cycle scl_oe=sda_oe=0; no rsp_valid; cmd_ready=1 after reset.
//   6 Back-to-back: cmd_valid held with a second command -> accepted the cycle after rsp_valid; both complete.

Source files
------------

// File: rtl/i2c_controller.sv
// ============================================================================
// Module      : i2c_controller
// Description : Single-master I2C controller, one single-byte write or read
//               per command, open-drain SCL/SDA via output-enable pins.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    input  logic       i2c_scl_i,
    output logic       i2c_scl_o,
    output logic       i2c_scl_oe,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_oe
);

    localparam logic [15:0] CNT_INIT = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_AACK  = 3'd3,
        S_DATA  = 3'd4,
        S_DACK  = 3'd5,
        S_STOP  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        nack_q, nack_d;
    logic        samp_q, samp_d;
    logic        ready_q, ready_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_nack_q, rsp_nack_d;

    logic w_busy, w_sample, w_bit_end, w_sda_bit, w_scl_oe, w_sda_oe;

    assign w_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w_sample  = (qtr_q == 2'd3) && (cnt_q == CNT_INIT);
    assign w_bit_end = (qtr_q == 2'd3) && (cnt_q == 16'd0);
    // With CLK_DIV=1 the sample and the bit end share a cycle, so bypass the flop.
    assign w_sda_bit = w_sample ? i2c_sda_i : samp_q;

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        nack_d      = nack_q;
        samp_d      = samp_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;
        w_scl_oe    = 1'b0;
        w_sda_oe    = 1'b0;

        // Quarter timing freezes in Q2 while a target stretches SCL low.
        if (w_busy && !((qtr_q == 2'd2) && !i2c_scl_i)) begin
            if (cnt_q == 16'd0) begin
                cnt_d = CNT_INIT;
                qtr_d = qtr_q + 2'd1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
        if (w_busy && w_sample) begin
            samp_d = i2c_sda_i;
        end

        case (state_q)
            S_IDLE: begin
                if (ready_q && cmd_valid) begin
                    state_d = S_START;
                    tx_d    = {cmd_addr, cmd_rw};
                    rw_d    = cmd_rw;
                    wdata_d = cmd_wdata;
                    nack_d  = 1'b0;
                    rx_d    = 8'h00;
                    bit_d   = 3'd0;
                    qtr_d   = 2'd0;
                    cnt_d   = CNT_INIT;
                end
            end
            S_START: begin
                w_sda_oe = qtr_q[1];
                if (w_bit_end) state_d = S_ADDR;
            end
            S_ADDR: begin
                w_scl_oe = ~qtr_q[1];
                w_sda_oe = ~tx_q[7];
                if (w_bit_end) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_AACK;
                end
            end
            S_AACK: begin
                w_scl_oe = ~qtr_q[1];
                if (w_bit_end) begin
                    if (w_sda_bit) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                        tx_d    = rw_q ? 8'hFF : wdata_q;
                    end
                end
            end
            S_DATA: begin
                w_scl_oe = ~qtr_q[1];
                w_sda_oe = ~tx_q[7];
                if (w_sample && rw_q) rx_d = {rx_q[6:0], i2c_sda_i};
                if (w_bit_end) begin
                    tx_d  = {tx_q[6:0], 1'b1};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_DACK;
                end
            end
            S_DACK: begin
                w_scl_oe = ~qtr_q[1];
                if (w_bit_end) begin
                    if (!rw_q && w_sda_bit) nack_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                w_scl_oe = ~qtr_q[1];
                w_sda_oe = ~qtr_q[1];
                if (w_bit_end) begin
                    state_d     = S_DONE;
                    rsp_rdata_d = rw_q ? rx_q : 8'h00;
                    rsp_nack_d  = nack_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            qtr_q       <= 2'd0;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            rw_q        <= 1'b0;
            wdata_q     <= 8'h00;
            nack_q      <= 1'b0;
            samp_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            nack_q      <= nack_d;
            samp_q      <= samp_d;
            ready_q     <= ready_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_nack   = rsp_nack_q;
    assign i2c_scl_o  = 1'b0;
    assign i2c_sda_o  = 1'b0;
    assign i2c_scl_oe = w_scl_oe;
    assign i2c_sda_oe = w_sda_oe;

endmodule

`default_nettype wire

// File: tb/tb_i2c_controller.sv
// ============================================================================
// Module      : tb_i2c_controller
// Description : Directed self-checking bench for i2c_controller with a small
//               behavioural I2C target on a wired-AND bus.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_controller;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       scl_o, scl_oe, sda_o, sda_oe;
    logic       scl_bus, sda_bus;

    logic        stretch;
    logic        tgt_en, tgt_rd, tgt_low;
    logic [7:0]  tgt_byte;
    logic        prev_scl, prev_sda;
    int          rises;
    logic [17:0] bits;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign scl_bus = ~scl_oe & ~stretch;
    assign sda_bus = ~sda_oe & ~tgt_low;

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_nack   (rsp_nack),
        .i2c_scl_i  (scl_bus),
        .i2c_scl_o  (scl_o),
        .i2c_scl_oe (scl_oe),
        .i2c_sda_i  (sda_bus),
        .i2c_sda_o  (sda_o),
        .i2c_sda_oe (sda_oe)
    );

    // Bit k is the k-th SCL high phase after START (1..8 addr, 9 ack, 10..17 data, 18 ack).
    function automatic logic tgt_drive(input int k);
        if (!tgt_en)                            return 1'b0;
        if (k == 9)                             return 1'b1;
        if (k >= 10 && k <= 17 && tgt_rd)       return ~tgt_byte[17 - k];
        if (k == 18 && !tgt_rd)                 return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        prev_scl <= scl_bus;
        prev_sda <= sda_bus;
        if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
            rises   <= 0;
            tgt_low <= 1'b0;
        end else if (!prev_scl && scl_bus) begin
            rises <= rises + 1;
            if (rises < 18) bits[17 - rises] <= sda_bus;
        end else if (prev_scl && !scl_bus) begin
            tgt_low <= tgt_drive(rises + 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is seen.
    task automatic do_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          input logic keep, output int wait_cyc, output int lat);
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        wait_cyc  = 0;
        while (!cmd_ready && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int w, lat, n, cnt;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 7'h00;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h00;
        stretch   = 1'b0;
        tgt_en    = 1'b0;
        tgt_rd    = 1'b0;
        tgt_byte  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_nack", rsp_nack, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // 1: write 0x42 <- 0x5A, target ACKs
        tgt_en = 1'b1;
        tgt_rd = 1'b0;
        do_cmd(7'h42, 1'b0, 8'h5A, 1'b0, w, lat);
        check("t1_lat", lat, 321);
        check("t1_nack", rsp_nack, 0);
        check("t1_rdata", rsp_rdata, 0);
        check("t1_bits", bits, {8'b10000100, 1'b0, 8'h5A, 1'b0});

        // 2: read 0x42, target returns 0xA5, controller NACKs the byte
        repeat (3) @(negedge clk);
        tgt_rd = 1'b1;
        do_cmd(7'h42, 1'b1, 8'h00, 1'b0, w, lat);
        check("t2_lat", lat, 321);
        check("t2_rdata", rsp_rdata, 8'hA5);
        check("t2_nack", rsp_nack, 0);
        check("t2_bits", bits, {8'b10000101, 1'b0, 8'hA5, 1'b1});

        // 3: nobody answers
        repeat (3) @(negedge clk);
        tgt_en = 1'b0;
        do_cmd(7'h42, 1'b1, 8'h00, 1'b0, w, lat);
        check("t3_lat", lat, 177);
        check("t3_nack", rsp_nack, 1);
        check("t3_rdata", rsp_rdata, 0);
        check("t3_ack_bit", bits[9], 1);
        check("t3_rises", rises, 10);

        // 4: target stretches SCL for 50 clk in the fourth address bit
        repeat (3) @(negedge clk);
        tgt_en = 1'b1;
        tgt_rd = 1'b0;
        fork
            do_cmd(7'h42, 1'b0, 8'h5A, 1'b0, w, lat);
            begin
                n = 0;
                while (!(rises == 3 && !scl_bus) && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                stretch = 1'b1;
                n = 0;
                while (scl_oe && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (50) @(posedge clk);
                @(negedge clk);
                stretch = 1'b0;
            end
        join
        check("t4_lat", lat, 371);
        check("t4_nack", rsp_nack, 0);
        check("t4_bits", bits, {8'b10000100, 1'b0, 8'h5A, 1'b0});

        // 6: back-to-back, cmd_valid held across the first response
        repeat (3) @(negedge clk);
        tgt_rd = 1'b0;
        do_cmd(7'h42, 1'b0, 8'h5A, 1'b1, w, lat);
        check("t6a_lat", lat, 321);
        check("t6a_nack", rsp_nack, 0);
        check("t6a_rdata", rsp_rdata, 0);
        tgt_rd = 1'b1;
        do_cmd(7'h42, 1'b1, 8'h00, 1'b0, w, lat);
        check("t6b_accept_delay", w, 1);
        check("t6b_lat", lat, 321);
        check("t6b_rdata", rsp_rdata, 8'hA5);

        // 5: reset in the middle of the data byte
        repeat (3) @(negedge clk);
        tgt_rd    = 1'b0;
        cmd_addr  = 7'h42;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h00;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(rises == 13 && !scl_bus) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t5_pre_scl_oe", scl_oe, 1);
        check("t5_pre_sda_oe", sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_scl_oe", scl_oe, 0);
        check("t5_sda_oe", sda_oe, 0);
        check("t5_ready_in_rst", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready", cmd_ready, 1);
        cnt = 0;
        repeat (400) begin
            if (rsp_valid) cnt++;
            @(negedge clk);
        end
        check("t5_no_rsp", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
